sync_gray_ptr_rx: RTL and testbench
===================================

// Module: sync_gray_ptr_rx
// PURPOSE
//  Multi-channel, depth-configurable receiver for Gray-coded FIFO pointers in one destination domain.
//  - Resynchronises CH_NUM Gray pointers from a foreign domain through SYNC_STAGES flops per bit.
//  - Converts each synchronised pointer to binary, flags pointer movement, and flags illegal multi-bit jumps.
//  - Instantiate once per destination domain. Async FIFO read side: r_clk, rx = write ptr.
//    Async FIFO write side: w_clk, rx = read ptr.
// PARAMETERS
//  ADDR_BIT     4  FIFO depth bits; pointer width PW = ADDR_BIT+1 (MSB = wrap bit)
//  SYNC_STAGES  2  synchroniser flops per bit; legal range 2..4
//  CH_NUM       1  number of independent pointer channels
//  STEP_CHECK   1  1 = enable Gray step-error detection, 0 = ptr_step_err tied 0
// PORTS
//  r_clk          in   1          destination clock
//  r_rst_n        in   1          asynchronous active-low reset
//  ptr_gray_in    in   CH_NUM*PW  foreign-domain Gray pointers; ch i = [i*PW +: PW]
//  err_clr        in   1          synchronous clear of all ptr_step_err bits
//  ptr_gray_sync  out  CH_NUM*PW  Gray pointers after the last sync stage
//  ptr_bin_sync   out  CH_NUM*PW  binary form of ptr_gray_sync, registered
//  ptr_changed    out  CH_NUM     1-cycle strobe: ptr_bin_sync[ch] updated to a new value this cycle
//  ptr_step_err   out  CH_NUM     sticky: consecutive synced Gray values differed in >1 bit
//  sync_valid     out  1          outputs meaningful; low until pipeline flushed after reset
// BEHAVIOUR
//  Reset
//  - r_rst_n low (asynchronous): every sync stage, ptr_gray_sync, ptr_bin_sync, ptr_changed,
//    ptr_step_err, sync_valid and the flush counter clear to 0 immediately.
//  - Release takes effect on the next r_clk rising edge.
//  Sync chain, per channel, per bit
//  - stage[0] <= ptr_gray_in; stage[k] <= stage[k-1]; ptr_gray_sync = stage[SYNC_STAGES-1].
//  - No logic between stages.
//  - Latency: an input stable before edge E appears on ptr_gray_sync after edge E+SYNC_STAGES-1,
//    i.e. SYNC_STAGES edges counting E.
//  Conversion, one extra register
//  - bin[PW-1] = g[PW-1]; bin[j] = bin[j+1] ^ g[j].
//  - ptr_bin_sync registered from ptr_gray_sync; total latency SYNC_STAGES+1 edges.
//  - Wrap-around: Gray 10000 -> 00000 (PW=5) converts to binary 11111 -> 00000. This is a normal
//    single step, not an error.
//  Change strobe
//  - ptr_changed[ch] = 1 for exactly the cycle in which the new ptr_bin_sync[ch] is first visible,
//    i.e. the registered value differs from its previous value.
//  - A pointer that holds keeps ptr_changed low. Channels are fully independent.
//  Step error (STEP_CHECK=1)
//  - Compare ptr_gray_sync with its value one cycle earlier.
//  - Hamming distance >= 2 sets ptr_step_err[ch] on the same edge that updates ptr_bin_sync.
//  - The bit holds until err_clr. If set and clear occur in the same cycle, set wins.
//  - The check is suppressed while sync_valid = 0.
//  - The check is only meaningful when the source advances at most once per r_clk period.
//    Faster sources must build with STEP_CHECK=0.
//  Flush / valid
//  - A counter counts r_clk edges after reset release, saturating at SYNC_STAGES+1.
//  - sync_valid goes 1 on the edge where the counter reaches SYNC_STAGES+1 and stays 1 until reset.
//  - ptr_changed is forced 0 while sync_valid = 0.
//  Reset mid-operation
//  - Asserting r_rst_n at any time discards all pipeline contents.
//  - After release, the whole flush sequence restarts.
// TESTING
//  1. Reset: hold r_rst_n=0 with ptr_gray_in=5'b10110.
//     -> all outputs 0. Release -> sync_valid rises after exactly 3 edges (SYNC_STAGES=2).
//  2. Latency: after valid, step ptr_gray_in 00000 -> 00001 before edge E.
//     -> ptr_gray_sync=00001 after E+1; ptr_bin_sync=00001 and ptr_changed=1 after E+2 only.
//  3. Wrap: walk Gray 0..31 then back to 00000, one step per 3 cycles.
//     -> binary output counts 0..31 then 0; 32 single-cycle strobes; no ptr_step_err.
//  4. Error: jump ptr_gray_in 00000 -> 00011.
//     -> ptr_step_err=1 and stays 1. err_clr pulse -> 0. err_clr together with a new bad jump -> stays 1.
//  5. Multi-channel/depth: CH_NUM=3, SYNC_STAGES=3; step only ch1.
//     -> only ptr_changed[1] pulses, 4 edges after the input change; ch0/ch2 outputs unchanged.
//  6. Mid-run reset: drop r_rst_n while a step is in flight.
//     -> outputs 0 at once, in-flight value lost; after release, sync_valid=0 for 3 edges, then resumes.

Source files
------------

// File: rtl/sync_gray_ptr_rx.sv
// Receives CH_NUM Gray-coded FIFO pointers from a foreign clock domain, resynchronises them,
// converts them to binary and flags pointer movement and illegal multi-bit Gray jumps.
module sync_gray_ptr_rx #(
  parameter int ADDR_BIT    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CH_NUM      = 1,
  parameter int STEP_CHECK  = 1
) (
  input  logic                               r_clk,
  input  logic                               r_rst_n,
  input  logic [CH_NUM*(ADDR_BIT+1)-1:0]     ptr_gray_in,
  input  logic                               err_clr,
  output logic [CH_NUM*(ADDR_BIT+1)-1:0]     ptr_gray_sync,
  output logic [CH_NUM*(ADDR_BIT+1)-1:0]     ptr_bin_sync,
  output logic [CH_NUM-1:0]                  ptr_changed,
  output logic [CH_NUM-1:0]                  ptr_step_err,
  output logic                               sync_valid
);

  localparam int PW = ADDR_BIT + 1;
  localparam int W  = CH_NUM * PW;
  localparam int CW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] FLUSH_MAX = CW'(SYNC_STAGES + 1);

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int j = PW - 2; j >= 0; j--) b[j] = b[j+1] ^ g[j];
    return b;
  endfunction

  // A nonzero difference with more than one bit set is an illegal Gray step.
  function automatic logic multi_bit(input logic [PW-1:0] d);
    return (d & (d - 1'b1)) != '0;
  endfunction

  logic [W-1:0]      r_sync [SYNC_STAGES];
  logic [W-1:0]      r_gray_prev;
  logic [W-1:0]      r_bin;
  logic [CH_NUM-1:0] r_changed;
  logic [CH_NUM-1:0] r_err;
  logic [CW-1:0]     r_cnt;
  logic              r_valid;

  logic [W-1:0]      w_gray_last;
  logic [W-1:0]      w_bin_d;
  logic [CH_NUM-1:0] w_chg_d;
  logic [CH_NUM-1:0] w_set;
  logic [CW-1:0]     w_cnt_inc;

  assign w_gray_last = r_sync[SYNC_STAGES-1];
  assign w_cnt_inc   = r_cnt + 1'b1;

  // Plain flop chain: no logic between stages so each bit resolves metastability independently.
  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= ptr_gray_in;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  // Strobe and error use the pre-edge valid, so the flush edge itself never reports garbage.
  always_comb begin
    w_bin_d = '0;
    w_chg_d = '0;
    w_set   = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      w_bin_d[c*PW +: PW] = gray2bin(w_gray_last[c*PW +: PW]);
      w_chg_d[c] = r_valid && (w_bin_d[c*PW +: PW] != r_bin[c*PW +: PW]);
      w_set[c]   = (STEP_CHECK != 0) && r_valid &&
                   multi_bit(w_gray_last[c*PW +: PW] ^ r_gray_prev[c*PW +: PW]);
    end
  end

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_gray_prev <= '0;
      r_bin       <= '0;
      r_changed   <= '0;
      r_err       <= '0;
      r_cnt       <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_gray_prev <= w_gray_last;
      r_bin       <= w_bin_d;
      r_changed   <= w_chg_d;
      r_err       <= (r_err & ~{CH_NUM{err_clr}}) | w_set;
      if (r_cnt != FLUSH_MAX) begin
        r_cnt   <= w_cnt_inc;
        r_valid <= (w_cnt_inc == FLUSH_MAX);
      end
    end
  end

  assign ptr_gray_sync = w_gray_last;
  assign ptr_bin_sync  = r_bin;
  assign ptr_changed   = r_changed & {CH_NUM{r_valid}};
  assign ptr_step_err  = r_err;
  assign sync_valid    = r_valid;

endmodule

// File: tb/tb_sync_gray_ptr_rx.sv
// Directed bench for sync_gray_ptr_rx: a single-channel 2-stage instance and a
// three-channel 3-stage instance share clock, reset and error clear.
module tb_sync_gray_ptr_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        err_clr;
  logic [4:0]  gin1;
  logic [4:0]  gs1, gb1;
  logic [0:0]  chg1, err1;
  logic        vld1;
  logic [14:0] gin3;
  logic [14:0] gs3, gb3;
  logic [2:0]  chg3, err3;
  logic        vld3;

  int n_checks = 0;
  int n_fail   = 0;
  int strobes;
  int s;
  logic [4:0] v, g;

  always #5 clk = ~clk;

  sync_gray_ptr_rx #(.ADDR_BIT(4), .SYNC_STAGES(2), .CH_NUM(1), .STEP_CHECK(1)) u_dut1 (
    .r_clk(clk), .r_rst_n(rst_n), .ptr_gray_in(gin1), .err_clr(err_clr),
    .ptr_gray_sync(gs1), .ptr_bin_sync(gb1), .ptr_changed(chg1),
    .ptr_step_err(err1), .sync_valid(vld1));

  sync_gray_ptr_rx #(.ADDR_BIT(4), .SYNC_STAGES(3), .CH_NUM(3), .STEP_CHECK(1)) u_dut3 (
    .r_clk(clk), .r_rst_n(rst_n), .ptr_gray_in(gin3), .err_clr(err_clr),
    .ptr_gray_sync(gs3), .ptr_bin_sync(gb3), .ptr_changed(chg3),
    .ptr_step_err(err3), .sync_valid(vld3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; err_clr = 1'b0; gin1 = 5'b10110; gin3 = '0;
    tick(); tick();
    chk("rst_gray", 32'(gs1), 32'h0);
    chk("rst_bin", 32'(gb1), 32'h0);
    chk("rst_chg", 32'(chg1), 32'h0);
    chk("rst_err", 32'(err1), 32'h0);
    chk("rst_vld", 32'(vld1), 32'h0);
    chk("rst_vld3", 32'(vld3), 32'h0);

    // Flush: valid after exactly three edges on the 2-stage instance.
    rst_n = 1'b1;
    tick(); chk("flush_e1", 32'(vld1), 32'h0);
    tick(); chk("flush_e2", 32'(vld1), 32'h0);
    tick(); chk("flush_e3", 32'(vld1), 32'h1);
    chk("flush_gray", 32'(gs1), 32'h16);
    chk("flush_bin", 32'(gb1), 32'h1b);
    chk("flush_chg", 32'(chg1), 32'h0);
    chk("flush_err", 32'(err1), 32'h0);
    chk("flush3_e3", 32'(vld3), 32'h0);
    gin1 = 5'b00000;
    tick(); chk("flush3_e4", 32'(vld3), 32'h1);

    // 10110 -> 00000 is a three-bit jump.
    tick(); tick(); tick();
    chk("jump_err_set", 32'(err1), 32'h1);
    chk("jump_bin", 32'(gb1), 32'h0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("jump_err_clr", 32'(err1), 32'h0);

    // Latency: 00000 -> 00001.
    gin1 = 5'b00001;
    tick(); chk("lat_e_gray", 32'(gs1), 32'h0);
    tick(); chk("lat_e1_gray", 32'(gs1), 32'h1);
    chk("lat_e1_bin", 32'(gb1), 32'h0);
    chk("lat_e1_chg", 32'(chg1), 32'h0);
    tick(); chk("lat_e2_bin", 32'(gb1), 32'h1);
    chk("lat_e2_chg", 32'(chg1), 32'h1);
    tick(); chk("lat_e3_chg", 32'(chg1), 32'h0);

    // Wrap walk: 0, 1..31, 0; strobes counted from step 1 onward.
    strobes = 0;
    for (int i = 0; i <= 32; i++) begin
      v = 5'(i % 32);
      g = v ^ (v >> 1);
      gin1 = g;
      s = 0;
      repeat (3) begin tick(); s += int'(chg1); end
      chk($sformatf("wrap_bin_%0d", i), 32'(gb1), 32'(v));
      if (i > 0) strobes += s;
    end
    chk("wrap_strobes", 32'(strobes), 32'd32);
    chk("wrap_err", 32'(err1), 32'h0);

    // Step error 00000 -> 00011, sticky, cleared, then set-wins-over-clear.
    gin1 = 5'b00011;
    tick(); tick(); tick();
    chk("step_err_set", 32'(err1), 32'h1);
    tick(); tick();
    chk("step_err_sticky", 32'(err1), 32'h1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("step_err_clr", 32'(err1), 32'h0);
    gin1 = 5'b00000;
    tick(); tick();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("set_wins", 32'(err1), 32'h1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("set_wins_clr", 32'(err1), 32'h0);

    // Multi-channel, 3 stages: only ch1 moves.
    gin3 = {5'd0, 5'b00001, 5'd0};
    tick(); tick(); tick();
    chk("mc_e2_chg", 32'(chg3), 32'h0);
    chk("mc_e2_gray", 32'(gs3), 32'h20);
    tick();
    chk("mc_e3_chg", 32'(chg3), 32'h2);
    chk("mc_e3_bin", 32'(gb3), 32'h20);
    chk("mc_err", 32'(err3), 32'h0);
    tick();
    chk("mc_e4_chg", 32'(chg3), 32'h0);

    // Mid-run reset with a step in flight.
    gin1 = 5'b00001;
    tick(); tick(); tick();
    chk("mr_pre_bin", 32'(gb1), 32'h1);
    gin1 = 5'b00011;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mr_async_gray", 32'(gs1), 32'h0);
    chk("mr_async_bin", 32'(gb1), 32'h0);
    chk("mr_async_vld", 32'(vld1), 32'h0);
    chk("mr_async_gb3", 32'(gb3), 32'h0);
    tick();
    rst_n = 1'b1;
    tick(); chk("mr_e1_vld", 32'(vld1), 32'h0);
    chk("mr_e1_gray", 32'(gs1), 32'h0);
    tick(); chk("mr_e2_vld", 32'(vld1), 32'h0);
    tick(); chk("mr_e3_vld", 32'(vld1), 32'h1);
    chk("mr_e3_bin", 32'(gb1), 32'h2);
    chk("mr_e3_chg", 32'(chg1), 32'h0);
    chk("mr_e3_err", 32'(err1), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
